// File: rtl/risc_core_mc.sv
// risc_core_mc -- small multi-cycle RISC core (FETCH / EXEC / MEM / HALT).
//
// Ports
//   clk          : single clock, all state updates on the rising edge
//   reset        : synchronous, active-high reset
//   instr_addr   : program counter, drives the instruction memory address
//   instr_data   : 16-bit instruction word, combinationally valid for instr_addr
//   data_req     : data-bus request, high for every MEM cycle
//   data_ready   : memory accepts/completes the transfer this cycle (MEM only)
//   data_write   : request is a store (data_req AND opcode SW)
//   data_addr    : load/store address, registered in EXEC
//   data_out     : store data, registered in EXEC
//   data_in      : load data, sampled when data_ready=1
//   halted       : core is in the HALT state
//   bus_err      : data-bus timeout occurred
//
// Optional feature: define RISC_CORE_MC_BUS_TIMEOUT_EN to abort a transfer
// after 16 consecutive MEM cycles without data_ready (sets bus_err, halts).
// Without it MEM waits indefinitely and bus_err is tied to 0.
module risc_core_mc #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 8
) (
   input  logic              clk,
   input  logic              reset,
   output logic [ADDR_W-1:0] instr_addr,
   input  logic [15:0]       instr_data,
   output logic              data_req,
   input  logic              data_ready,
   output logic              data_write,
   output logic [ADDR_W-1:0] data_addr,
   output logic [DATA_W-1:0] data_out,
   input  logic [DATA_W-1:0] data_in,
   output logic              halted,
   output logic              bus_err
);

   localparam logic [3:0] OP_ADD  = 4'b0000;
   localparam logic [3:0] OP_SUB  = 4'b0001;
   localparam logic [3:0] OP_LW   = 4'b0010;
   localparam logic [3:0] OP_SW   = 4'b0011;
   localparam logic [3:0] OP_BEQ  = 4'b0100;
   localparam logic [3:0] OP_JMP  = 4'b0101;
   localparam logic [3:0] OP_AND  = 4'b0110;
   localparam logic [3:0] OP_OR   = 4'b0111;
   localparam logic [3:0] OP_LI   = 4'b1000;
   localparam logic [3:0] OP_HALT = 4'b1111;

   typedef enum logic [1:0] {S_FETCH, S_EXEC, S_MEM, S_HALT} state_t;

   state_t             state, state_n;
   logic [ADDR_W-1:0]  pc, pc_n;
   logic [15:0]        ir;
   logic [DATA_W-1:0]  rf [4];

   logic               ir_ld;
   logic               mem_ld;
   logic               rf_we;
   logic [1:0]         rf_wa;
   logic [DATA_W-1:0]  rf_wd;

   // Instruction fields; R-type rs/rt share bit positions with I-type ra/rb
   logic [3:0]         op;
   logic [1:0]         f_rs, f_rt, f_rd;
   logic [7:0]         imm8;
   logic signed [7:0]  imm8_s;
   logic [DATA_W-1:0]  rs_val, rt_val;
   logic [ADDR_W-1:0]  pc_inc, pc_br, br_off, mem_addr;

   assign op     = ir[15:12];
   assign f_rs   = ir[11:10];
   assign f_rt   = ir[9:8];
   assign f_rd   = ir[7:6];
   assign imm8   = ir[7:0];
   assign imm8_s = signed'(imm8);

   // R0 reads as zero regardless of storage contents
   assign rs_val = (f_rs == 2'd0) ? '0 : rf[f_rs];
   assign rt_val = (f_rt == 2'd0) ? '0 : rf[f_rt];

   // Size casts zero-extend/truncate imm8; the signed cast sign-extends the branch offset
   assign pc_inc   = pc + ADDR_W'(1);
   assign br_off   = ADDR_W'(imm8_s);
   assign pc_br    = pc_inc + br_off;
   assign mem_addr = ADDR_W'(rs_val) + ADDR_W'(imm8);

`ifdef RISC_CORE_MC_BUS_TIMEOUT_EN
   logic [3:0] to_cnt;
   logic       berr_q;
   logic       berr_set;
   assign bus_err = berr_q;
`else
   assign bus_err = 1'b0;
`endif

   assign instr_addr = pc;
   assign data_req   = (state == S_MEM);
   assign data_write = data_req && (op == OP_SW);
   assign halted     = (state == S_HALT);

   always_comb begin
      state_n = state;
      pc_n    = pc;
      ir_ld   = 1'b0;
      mem_ld  = 1'b0;
      rf_we   = 1'b0;
      rf_wa   = f_rd;
      rf_wd   = '0;
`ifdef RISC_CORE_MC_BUS_TIMEOUT_EN
      berr_set = 1'b0;
`endif
      case (state)
         S_FETCH: begin
            ir_ld   = 1'b1;
            state_n = S_EXEC;
         end
         S_EXEC: begin
            state_n = S_FETCH;
            pc_n    = pc_inc;
            case (op)
               OP_ADD: begin rf_we = 1'b1; rf_wd = rs_val + rt_val; end
               OP_SUB: begin rf_we = 1'b1; rf_wd = rs_val - rt_val; end
               OP_AND: begin rf_we = 1'b1; rf_wd = rs_val & rt_val; end
               OP_OR:  begin rf_we = 1'b1; rf_wd = rs_val | rt_val; end
               OP_LI: begin
                  rf_we = 1'b1;
                  rf_wa = f_rt;
                  rf_wd = DATA_W'(imm8);
               end
               OP_BEQ: if (rs_val == rt_val) pc_n = pc_br;
               OP_JMP: pc_n = ADDR_W'(imm8);
               OP_LW, OP_SW: begin
                  mem_ld  = 1'b1;
                  pc_n    = pc;
                  state_n = S_MEM;
               end
               OP_HALT: begin
                  pc_n    = pc;
                  state_n = S_HALT;
               end
               default: ;
            endcase
         end
         S_MEM: begin
            if (data_ready) begin
               if (op == OP_LW) begin
                  rf_we = 1'b1;
                  rf_wa = f_rt;
                  rf_wd = data_in;
               end
               pc_n    = pc_inc;
               state_n = S_FETCH;
            end
`ifdef RISC_CORE_MC_BUS_TIMEOUT_EN
            // 16th consecutive not-ready cycle: give up, no write, PC kept
            else if (to_cnt == 4'd15) begin
               berr_set = 1'b1;
               state_n  = S_HALT;
            end
`endif
         end
         default: ;  // S_HALT is absorbing
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= S_FETCH;
         pc        <= '0;
         ir        <= '0;
         data_addr <= '0;
         data_out  <= '0;
         for (int i = 0; i < 4; i++) rf[i] <= '0;
`ifdef RISC_CORE_MC_BUS_TIMEOUT_EN
         to_cnt    <= '0;
         berr_q    <= 1'b0;
`endif
      end else begin
         state <= state_n;
         pc    <= pc_n;
         if (ir_ld) ir <= instr_data;
         if (rf_we && rf_wa != 2'd0) rf[rf_wa] <= rf_wd;
         if (mem_ld) begin
            data_addr <= mem_addr;
            data_out  <= rt_val;
         end
`ifdef RISC_CORE_MC_BUS_TIMEOUT_EN
         if (state == S_MEM && !data_ready) to_cnt <= to_cnt + 4'd1;
         else                               to_cnt <= '0;
         if (berr_set) berr_q <= 1'b1;
`endif
      end
   end

endmodule

// File: tb/tb_risc_core_mc.sv
module tb_risc_core_mc;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        drdy = 1'b0;

   logic [7:0]  ia, daddr, dout, din;
   logic [15:0] id;
   logic        dreq, dwr, hlt, berr;

   logic [3:0]  ia4, daddr4;
   logic [15:0] id4;
   logic [7:0]  dout4;
   logic        dreq4, dwr4, hlt4, berr4;

   logic [15:0] imem  [256];
   logic [15:0] imem4 [16];
   logic [7:0]  dmem  [256];

   int n_chk = 0;
   int n_err = 0;
   int st_cnt = 0;
   logic [7:0] st_addr, st_data;

   always #5 clk = ~clk;

   assign id  = imem[ia];
   assign din = dmem[daddr];
   assign id4 = imem4[ia4];

   risc_core_mc dut (
      .clk(clk), .reset(reset), .instr_addr(ia), .instr_data(id),
      .data_req(dreq), .data_ready(drdy), .data_write(dwr), .data_addr(daddr),
      .data_out(dout), .data_in(din), .halted(hlt), .bus_err(berr)
   );

   risc_core_mc #(.DATA_W(8), .ADDR_W(4)) dut4 (
      .clk(clk), .reset(reset), .instr_addr(ia4), .instr_data(id4),
      .data_req(dreq4), .data_ready(drdy), .data_write(dwr4), .data_addr(daddr4),
      .data_out(dout4), .data_in(8'h00), .halted(hlt4), .bus_err(berr4)
   );

   // Memory model: store completes on the edge with data_ready=1
   always @(posedge clk) begin
      if (!reset && dreq && dwr && drdy) begin
         dmem[daddr] = dout;
         st_addr     = daddr;
         st_data     = dout;
         st_cnt++;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_mem();
      for (int i = 0; i < 256; i++) begin
         imem[i] = 16'hC000;  // unused opcode -> NOP
         dmem[i] = 8'h00;
      end
      st_cnt = 0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
   endtask

   task automatic run_to_halt(input int max, output int n);
      n = 0;
      while (!hlt && n < max) begin
         tick();
         n++;
      end
      chk("halt_reached", hlt, 1);
   endtask

   initial begin
      int n;
      int reqn;

      for (int i = 0; i < 16; i++) imem4[i] = 16'hC000;
      imem4[0] = 16'h500F;  // JMP 15

      // Load/load/add/store/halt program
      clear_mem();
      imem[0] = 16'h2108;  // LW R1,8(R0)
      imem[1] = 16'h2209;  // LW R2,9(R0)
      imem[2] = 16'h06C0;  // ADD R3,R1,R2
      imem[3] = 16'h330A;  // SW R3,10(R0)
      imem[4] = 16'hF000;  // HALT
      dmem[8] = 8'h0A;
      dmem[9] = 8'h01;
      drdy = 1'b1;
      do_reset();
      chk("rst_pc", ia, 0);
      chk("rst_req", dreq, 0);
      run_to_halt(100, n);
      chk("prog_cycles", n, 13);
      chk("st_count", st_cnt, 1);
      chk("st_addr", st_addr, 8'h0A);
      chk("st_data", st_data, 8'h0B);
      chk("r3", dut.rf[3], 8'h0B);
      chk("halt_pc", ia, 4);
      chk("halt_req", dreq, 0);
      chk("halt_berr", berr, 0);
      tick(); tick();
      chk("halt_pc_frozen", ia, 4);

      // Reset after a run clears everything observable
      reset = 1'b1;
      tick();
      chk("rst_pc2", ia, 0);
      chk("rst_req2", dreq, 0);
      chk("rst_wr2", dwr, 0);
      chk("rst_daddr2", daddr, 0);
      chk("rst_dout2", dout, 0);
      chk("rst_halted2", hlt, 0);
      chk("rst_berr2", berr, 0);
      chk("rst_r3", dut.rf[3], 0);
      reset = 1'b0;

      // LW with three not-ready MEM cycles
      clear_mem();
      imem[0] = 16'h8133;  // LI R1,0x33
      imem[1] = 16'h2105;  // LW R1,5(R0)
      imem[2] = 16'hF000;
      dmem[5] = 8'h77;
      drdy = 1'b0;
      do_reset();
      tick(); tick(); tick(); tick();
      reqn = 0;
      for (int k = 0; k < 3; k++) begin
         if (dreq) reqn++;
         chk("wait_addr", daddr, 5);
         chk("wait_wr", dwr, 0);
         tick();
      end
      drdy = 1'b1;
      if (dreq) reqn++;
      chk("wait_r1_old", dut.rf[1], 8'h33);
      tick();
      if (dreq) reqn++;
      drdy = 1'b0;
      chk("wait_req_cycles", reqn, 4);
      chk("wait_r1_new", dut.rf[1], 8'h77);
      chk("wait_pc", ia, 2);

      // BEQ taken and not taken
      clear_mem();
      imem[0] = 16'h8105;  // LI R1,5
      imem[1] = 16'h8205;  // LI R2,5
      imem[2] = 16'h46FD;  // BEQ R1,R2,-3
      imem[3] = 16'hF000;
      drdy = 1'b1;
      do_reset();
      tick(); tick(); tick(); tick();
      chk("beq_pc_before", ia, 2);
      tick(); tick();
      chk("beq_taken_pc", ia, 0);
      imem[1] = 16'h8206;  // LI R2,6
      do_reset();
      for (int k = 0; k < 6; k++) tick();
      chk("beq_nt_pc", ia, 3);
      run_to_halt(20, n);
      chk("beq_nt_halt_pc", ia, 3);

      // PC wrap with ADDR_W=4
      do_reset();
      tick(); tick();
      chk("jmp15_pc", ia4, 15);
      tick(); tick();
      chk("wrap_pc", ia4, 0);

      // ALU ops, wrap, R0 discard, base+offset address wrap
      clear_mem();
      imem[0]  = 16'h810C;  // LI R1,0x0C
      imem[1]  = 16'h820A;  // LI R2,0x0A
      imem[2]  = 16'h16C0;  // SUB R3,R1,R2
      imem[3]  = 16'h3320;  // SW R3,0x20
      imem[4]  = 16'h66C0;  // AND R3,R1,R2
      imem[5]  = 16'h3321;
      imem[6]  = 16'h76C0;  // OR R3,R1,R2
      imem[7]  = 16'h3322;
      imem[8]  = 16'h19C0;  // SUB R3,R2,R1
      imem[9]  = 16'h3323;
      imem[10] = 16'h8007;  // LI R0,7
      imem[11] = 16'h3024;  // SW R0,0x24
      imem[12] = 16'h0FC0;  // ADD R3,R3,R3
      imem[13] = 16'h3325;
      imem[14] = 16'h37FF;  // SW R3,0xFF(R1)
      imem[15] = 16'hF000;
      dmem[8'h24] = 8'h55;
      do_reset();
      run_to_halt(200, n);
      chk("sub", dmem[8'h20], 8'h02);
      chk("and", dmem[8'h21], 8'h08);
      chk("or", dmem[8'h22], 8'h0E);
      chk("sub_wrap", dmem[8'h23], 8'hFE);
      chk("r0_zero", dmem[8'h24], 8'h00);
      chk("add_wrap", dmem[8'h25], 8'hFC);
      chk("addr_wrap", dmem[8'h0B], 8'hFC);
      chk("alu_st_count", st_cnt, 7);

      // Reset during MEM with data_ready=1 aborts the load
      clear_mem();
      imem[0] = 16'h8244;  // LI R2,0x44
      imem[1] = 16'h2206;  // LW R2,6(R0)
      dmem[6] = 8'h99;
      drdy = 1'b0;
      do_reset();
      tick(); tick(); tick(); tick();
      chk("abort_in_mem", dreq, 1);
      chk("abort_r2_pre", dut.rf[2], 8'h44);
      drdy = 1'b1;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      drdy = 1'b0;
      chk("abort_r2", dut.rf[2], 0);
      chk("abort_pc", ia, 0);
      chk("abort_req", dreq, 0);

      // Data bus never ready
      clear_mem();
      imem[0] = 16'h2105;  // LW R1,5(R0)
      imem[1] = 16'hF000;
      drdy = 1'b0;
      do_reset();
      tick(); tick();
`ifdef RISC_CORE_MC_BUS_TIMEOUT_EN
      for (int k = 0; k < 15; k++) tick();
      chk("to_req_c16", dreq, 1);
      chk("to_berr_c16", berr, 0);
      tick();
      chk("to_berr", berr, 1);
      chk("to_halted", hlt, 1);
      chk("to_req", dreq, 0);
      chk("to_pc", ia, 0);
      chk("to_r1", dut.rf[1], 0);
      drdy = 1'b1;
      tick(); tick();
      chk("to_berr_sticky", berr, 1);
      drdy = 1'b0;
`else
      for (int k = 0; k < 40; k++) tick();
      chk("nto_req", dreq, 1);
      chk("nto_berr", berr, 0);
      chk("nto_halted", hlt, 0);
      chk("nto_addr", daddr, 5);
`endif

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
